// File: rtl/traffic_pkg.sv
// Shared definitions for the highway / farm-road intersection sequencer.
//   - State encodings HG/HY/FG/FY (2-bit, kept as plain localparams so the
//     encoding stays fixed for anything that decodes the raw state).
//   - Signal-head light codes RED/YELLOW/GREEN.
//   - heads_for_state(): Moore decode of state to both signal heads.
package traffic_pkg;

    localparam logic [1:0] HG = 2'd0;   // highway green
    localparam logic [1:0] HY = 2'd1;   // highway yellow
    localparam logic [1:0] FG = 2'd2;   // farm green
    localparam logic [1:0] FY = 2'd3;   // farm yellow

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    typedef struct packed {
        logic [1:0] hwy;
        logic [1:0] farm;
    } heads_t;

    function automatic heads_t heads_for_state(input logic [1:0] st);
        heads_t h;
        h = '{hwy: GREEN, farm: RED};
        case (st)
            HG:      h = '{hwy: GREEN,  farm: RED};
            HY:      h = '{hwy: YELLOW, farm: RED};
            FG:      h = '{hwy: RED,    farm: GREEN};
            FY:      h = '{hwy: RED,    farm: YELLOW};
            default: h = '{hwy: GREEN,  farm: RED};
        endcase
        return h;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Reloadable saturating down-counter that times each light phase.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset, count returns to RST_VAL
//   load      reload count with load_val this edge (has priority)
//   load_val  reload value (phase length minus one)
//   count     current count (cycles remaining in the phase)
//   zero      high while count == 0, i.e. the last cycle of the phase
module phase_timer #(
    parameter int N = 11,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         zero
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    // Count holds at zero rather than wrapping, so a phase with no exit
    // condition (highway green with no demand) simply parks at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Highway / farm-road intersection sequencer.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   car         farm-road vehicle present (level)
//   ped_req     pedestrian button, latched until served
//   hwy_light   highway head (00 red, 01 yellow, 10 green)
//   farm_light  farm head, same encoding
//   walk        pedestrian WALK lamp (farm green with a served request)
//   Timing      cycles remaining in the current phase
//   phase_done  high in the last cycle of the current phase
module traffic_light_sequencer
    import traffic_pkg::*;
#(
    parameter int N       = 11,
    parameter int T_SHORT = 3,
    parameter int T_LONG  = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         car,
    input  logic         ped_req,
    output logic [1:0]   hwy_light,
    output logic [1:0]   farm_light,
    output logic         walk,
    output logic [N-1:0] Timing,
    output logic         phase_done
);

    localparam logic [N-1:0] LONG_RELOAD  = N'(T_LONG - 1);
    localparam logic [N-1:0] SHORT_RELOAD = N'(T_SHORT - 1);

    logic [1:0]   state_q, state_d;
    logic         ped_pending_q, ped_pending_d;
    logic         walk_served_q, walk_served_d;
    logic         timer_load;
    logic [N-1:0] timer_load_val;
    logic [N-1:0] timer_count;
    logic         timer_zero;
    logic         serve_edge;
    heads_t       heads;

    always_comb begin
        state_d = state_q;
        case (state_q)
            HG: if (timer_zero && (car || ped_pending_q)) state_d = HY;
            HY: if (timer_zero) state_d = FG;
            // Gap-out: with no car waiting and no walk being served the
            // farm green is cut short on the very next edge.
            FG: if (timer_zero || (!car && !walk_served_q)) state_d = FY;
            FY: if (timer_zero) state_d = HG;
            default: state_d = HG;
        endcase
    end

    // Any state change restarts the timer with the new phase's length.
    assign timer_load     = (state_d != state_q);
    assign timer_load_val = (state_d == HY || state_d == FY) ? SHORT_RELOAD : LONG_RELOAD;

    // Entering farm green hands the pending request over to the walk
    // flag; a button press landing on that same edge is absorbed.
    assign serve_edge = (state_q == HY) && (state_d == FG);

    always_comb begin
        ped_pending_d = ped_pending_q | ped_req;
        walk_served_d = walk_served_q;
        if (serve_edge) begin
            ped_pending_d = 1'b0;
            walk_served_d = ped_pending_q;
        end else if (state_q == FG && state_d != FG) begin
            walk_served_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HG;
            ped_pending_q <= 1'b0;
            walk_served_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            walk_served_q <= walk_served_d;
        end
    end

    phase_timer #(
        .N       (N),
        .RST_VAL (LONG_RELOAD)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .count    (timer_count),
        .zero     (timer_zero)
    );

    assign heads      = heads_for_state(state_q);
    assign hwy_light  = heads.hwy;
    assign farm_light = heads.farm;
    assign walk       = (state_q == FG) && walk_served_q;
    assign Timing     = timer_count;
    assign phase_done = timer_zero;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Bench for traffic_light_sequencer: a table of directed vectors, a few
// hand-written multi-cycle sequences and a randomized run, each cycle
// compared against a phase/elapsed-time reference model.
module tb_traffic_light_sequencer;

    localparam int N       = 11;
    localparam int T_SHORT = 3;
    localparam int T_LONG  = 7;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         car = 1'b0;
    logic         ped_req = 1'b0;
    logic [1:0]   hwy_light;
    logic [1:0]   farm_light;
    logic         walk;
    logic [N-1:0] Timing;
    logic         phase_done;

    int n_checks = 0;
    int n_fails  = 0;

    traffic_light_sequencer #(
        .N       (N),
        .T_SHORT (T_SHORT),
        .T_LONG  (T_LONG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .car        (car),
        .ped_req    (ped_req),
        .hwy_light  (hwy_light),
        .farm_light (farm_light),
        .walk       (walk),
        .Timing     (Timing),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    // Reference model: phase number (0 hwy green, 1 hwy yellow, 2 farm
    // green, 3 farm yellow) plus cycles elapsed since the phase began.
    int m_ph = 0;
    int m_el = 0;
    bit m_pend = 1'b0;
    bit m_served = 1'b0;
    int hwy_of[4]  = '{2, 1, 0, 0};
    int farm_of[4] = '{0, 0, 2, 1};

    function automatic int phase_len(input int ph);
        return (ph == 1 || ph == 3) ? T_SHORT : T_LONG;
    endfunction

    function automatic int model_rem();
        int d;
        d = phase_len(m_ph);
        return (m_el >= d - 1) ? 0 : d - 1 - m_el;
    endfunction

    function automatic logic [16:0] model_out();
        int rem;
        rem = model_rem();
        return {2'(hwy_of[m_ph]), 2'(farm_of[m_ph]), (m_ph == 2) && m_served,
                11'(rem), rem == 0};
    endfunction

    task automatic model_edge(input bit r, input bit c, input bit p);
        int  nxt;
        bit  done;
        if (r) begin
            m_ph = 0; m_el = 0; m_pend = 0; m_served = 0;
            return;
        end
        done = (model_rem() == 0);
        nxt  = m_ph;
        case (m_ph)
            0: if (done && (c || m_pend)) nxt = 1;
            1: if (done) nxt = 2;
            2: if (done || (!c && !m_served)) nxt = 3;
            default: if (done) nxt = 0;
        endcase
        if (m_ph == 1 && nxt == 2) begin
            m_served = m_pend;
            m_pend   = 0;
        end else begin
            if (p) m_pend = 1;
            if (m_ph == 2 && nxt != 2) m_served = 0;
        end
        if (nxt != m_ph) m_el = 0;
        else if (m_el < 1000000) m_el++;
        m_ph = nxt;
    endtask

    function automatic logic [16:0] dut_out();
        return {hwy_light, farm_light, walk, Timing, phase_done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the
    // rising edge, sample 1 time unit later and compare with the model.
    task automatic step(input bit r, input bit c, input bit p);
        @(negedge clk);
        reset = r; car = c; ped_req = p;
        @(posedge clk);
        model_edge(r, c, p);
        #1;
        check("model", 32'(dut_out()), 32'(model_out()));
    endtask

    typedef struct {
        bit         rst, c, p;
        logic [1:0] hwy, farm;
        logic       wk;
        int         tim;
        logic       done;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input bit r, input bit c, input bit p, input logic [1:0] h,
                                input logic [1:0] f, input logic w, input int t);
        vec_t v;
        v = '{rst: r, c: c, p: p, hwy: h, farm: f, wk: w, tim: t, done: (t == 0)};
        return v;
    endfunction

    initial begin
        logic [1:0] G, Y, R;
        int guard;
        G = 2'b10; Y = 2'b01; R = 2'b00;

        // Reset, idle highway green, car-triggered cycle with gap-out,
        // then a pedestrian-only cycle that holds the full farm green.
        tv.push_back(mk(1, 0, 0, G, R, 0, 6));
        for (int t = 5; t >= 0; t--) tv.push_back(mk(0, 0, 0, G, R, 0, t));
        tv.push_back(mk(0, 0, 0, G, R, 0, 0));
        tv.push_back(mk(0, 1, 0, Y, R, 0, 2));
        tv.push_back(mk(0, 1, 0, Y, R, 0, 1));
        tv.push_back(mk(0, 1, 0, Y, R, 0, 0));
        tv.push_back(mk(0, 1, 0, R, G, 0, 6));
        tv.push_back(mk(0, 1, 0, R, G, 0, 5));
        tv.push_back(mk(0, 0, 0, R, Y, 0, 2));
        tv.push_back(mk(0, 0, 0, R, Y, 0, 1));
        tv.push_back(mk(0, 0, 0, R, Y, 0, 0));
        tv.push_back(mk(0, 0, 0, G, R, 0, 6));
        tv.push_back(mk(0, 0, 1, G, R, 0, 5));
        for (int t = 4; t >= 0; t--) tv.push_back(mk(0, 0, 0, G, R, 0, t));
        for (int t = 2; t >= 0; t--) tv.push_back(mk(0, 0, 0, Y, R, 0, t));
        for (int t = 6; t >= 0; t--) tv.push_back(mk(0, 0, 0, R, G, 1, t));
        for (int t = 2; t >= 0; t--) tv.push_back(mk(0, 0, 0, R, Y, 0, t));
        tv.push_back(mk(0, 0, 0, G, R, 0, 6));

        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].c, tv[i].p);
            check($sformatf("vec%0d", i), 32'(dut_out()),
                  32'({tv[i].hwy, tv[i].farm, tv[i].wk, 11'(tv[i].tim), tv[i].done}));
            $display("vec %0d: rst=%0b car=%0b ped=%0b -> hwy=%b farm=%b walk=%0b Timing=%0d done=%0b",
                     i, tv[i].rst, tv[i].c, tv[i].p, hwy_light, farm_light, walk, Timing, phase_done);
        end

        // Pedestrian press during farm green with cars present: walk is
        // unaffected now, but the request alone drives the next cycle.
        step(1, 0, 0);
        guard = 0;
        while (farm_light != 2'b10 && guard < 30) begin step(0, 1, 0); guard++; end
        check("reach_fg1", 32'(farm_light), 32'(2'b10));
        step(0, 1, 1);
        check("fg_walk_unchanged", 32'(walk), 32'd0);
        guard = 0;
        while (hwy_light != 2'b10 && guard < 30) begin step(0, 1, 0); guard++; end
        check("back_to_hg", 32'(hwy_light), 32'(2'b10));
        guard = 0;
        while (farm_light != 2'b10 && guard < 40) begin step(0, 0, 0); guard++; end
        check("ped_fg_walk", 32'({farm_light, walk}), 32'({2'b10, 1'b1}));
        $display("seq ped_in_fg: farm=%b walk=%0b after %0d cycles", farm_light, walk, guard);

        // Reset in the middle of farm green with a request being served.
        step(1, 1, 0);
        step(0, 0, 1);
        guard = 0;
        while (farm_light != 2'b10 && guard < 30) begin step(0, 1, 0); guard++; end
        guard = 0;
        while (Timing != 11'd3 && guard < 10) begin step(0, 1, 0); guard++; end
        check("fg_t3", 32'({farm_light, walk, Timing}), 32'({2'b10, 1'b1, 11'd3}));
        step(1, 1, 1);
        check("mid_fg_reset", 32'(dut_out()), 32'({2'b10, 2'b00, 1'b0, 11'd6, 1'b0}));
        for (int k = 0; k < 12; k++) step(0, 0, 0);
        check("pend_cleared", 32'({hwy_light, Timing, phase_done}), 32'({2'b10, 11'd0, 1'b1}));
        $display("seq mid_fg_reset: hwy=%b Timing=%0d done=%0b", hwy_light, Timing, phase_done);

        // Randomized traffic with occasional resets.
        step(1, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            bit r, c, p;
            r = ($urandom_range(0, 199) == 0);
            c = ((k / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 24) == 0);
            step(r, c, p);
        end
        $display("random run: 3000 cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
